mmio_ctrl: RTL and testbench
============================

MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the CPU data bus width.
REQ-002 SHALL have parameter ADDR_W, default 9, meaning the CPU address width.
REQ-003 SHALL have parameter N_OUT, default 2, range 1..32, meaning the number of output port registers.
REQ-004 SHALL have parameter N_IN, default 2, range 1..32, meaning the number of input ports.
REQ-005 SHALL have parameter IO_BASE, default 9'h100, meaning the I/O region base; IO_BASE[ADDR_W-1] is 1 and the low 7 bits are 0.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-008 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port mem_cmd, input, 2 bits: 00 NONE, 01 READ, 10 WRITE; 11 is treated as NONE.
REQ-010 SHALL have port mem_addr, input, ADDR_W bits: the CPU address.
REQ-011 SHALL have port write_data, input, DATA_W bits: CPU write data.
REQ-012 SHALL have port ram_dout, input, DATA_W bits: RAM read data.
REQ-013 SHALL have port in_ports, input, N_IN*DATA_W bits: asynchronous inputs; port i occupies bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port read_data, output, DATA_W bits: read data returned to the CPU.
REQ-015 SHALL have port ram_write, output, 1 bit: RAM write strobe.
REQ-016 SHALL have port out_ports, output, N_OUT*DATA_W bits: output register contents.
REQ-017 SHALL have port irq, output, 1 bit: the timer expired flag.

Function
REQ-018 SHALL treat an access as a RAM access when mem_addr[ADDR_W-1]==0 and as an I/O access otherwise; offsets below are mem_addr[6:0] relative to IO_BASE.
REQ-019 SHALL assert ram_write combinationally exactly when mem_cmd==WRITE and the access is a RAM access.
REQ-020 SHALL drive read_data combinationally as follows: ram_dout for a READ to RAM; the addressed register for a READ to a mapped I/O offset; 0 for a READ to an unmapped I/O offset and for any non-READ cycle. read_data never goes to Z.
REQ-021 SHALL map OUT[i] at offsets 0x00..N_OUT-1 (R/W); a WRITE updates the register at the next clk edge, and out_ports reflects the register directly.
REQ-022 SHALL map IN[i] at offsets 0x40..0x40+N_IN-1 (RO): each port passes through a 2-flop synchronizer, and reads return the second-stage value, so an input change is readable 2 cycles later.
REQ-023 SHALL map EDGE at offset 0x60: bit j of an internal sticky register sets on a rising edge of synchronized IN[0][j] (second stage is 1, third stage is 0).
REQ-024 SHALL clear EDGE by write-1-to-clear; when a clear and a new edge coincide on the same bit, the set wins.
REQ-025 SHALL map TLOAD at offset 0x70 (R/W): a write stores the value and also loads TCOUNT.
REQ-026 SHALL map TCTRL at offset 0x71: bit0 EN (R/W), bit1 AUTO (R/W), bit2 EXP (sticky; write-1-to-clear); all other bits read 0.
REQ-027 SHALL map TCOUNT at offset 0x72 (RO), DATA_W bits wide.
REQ-028 SHALL decrement TCOUNT by 1 per cycle while EN==1 and TCOUNT!=0.
REQ-029 SHALL set EXP when EN==1 and TCOUNT==0; in that cycle TCOUNT reloads from TLOAD if AUTO==1, otherwise EN clears.
REQ-030 SHALL give an EXP set priority over a simultaneous EXP write-1-to-clear.
REQ-031 SHALL let a TLOAD write take priority over a decrement or reload in the same cycle.
REQ-032 SHALL set EXP immediately (one cycle after EN sets) when TLOAD==0 and AUTO==1.
REQ-033 SHALL drive irq equal to EXP.
REQ-034 SHALL ignore writes to RO or unmapped I/O offsets, with no side effects; reads have no side effects.

Reset
REQ-035 SHALL, on reset, clear all OUT registers, synchronizer stages, EDGE, TLOAD, TCOUNT, EN, AUTO and EXP to 0, so out_ports=0 and irq=0 after the reset edge.
REQ-036 SHALL let reset override any simultaneous write or timer event, and SHALL suppress edge detection during reset.

Verification
REQ-037 Bench SHALL cover: WRITE 0x00A5 to 0x101 then READ 0x101 -> out_ports[31:16]=0x00A5 and read_data=0x00A5; READ 0x1FF -> read_data=0.
REQ-038 Bench SHALL cover: in_ports[0] changes 0->0x0003 -> READ 0x140 returns 0 for 2 cycles, then 0x0003; EDGE=0x0003 one cycle later; write 0x0001 to 0x160 -> EDGE=0x0002.
REQ-039 Bench SHALL cover: WRITE 3 to 0x170, WRITE 0x1 to 0x171 -> TCOUNT reads 3,2,1,0, then EXP=1, irq=1 and EN=0; WRITE 0x4 to 0x171 -> irq=0.
REQ-040 Bench SHALL cover: AUTO mode with TLOAD=2 -> EXP sets every 3 cycles; a W1C of EXP on an expiry cycle leaves irq=1.
REQ-041 Bench SHALL cover: WRITE 0x1234 to 0x010 -> ram_write=1 and no I/O register changes; READ 0x010 with ram_dout=0xBEEF -> read_data=0xBEEF.
REQ-042 Bench SHALL cover: assert reset while the timer is running and OUT[0]=0xFFFF -> next cycle all registers read 0 and irq=0.

Source files
------------

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: splits CPU accesses between RAM and an I/O window holding
// output registers, synchronized inputs with rising-edge capture, and a down-counting timer.
module mmio_ctrl #(
  parameter int unsigned          DATA_W  = 16,
  parameter int unsigned          ADDR_W  = 9,
  parameter int unsigned          N_OUT   = 2,
  parameter int unsigned          N_IN    = 2,
  parameter logic [ADDR_W-1:0]    IO_BASE = 9'h100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mem_cmd,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       write_data,
  input  logic [DATA_W-1:0]       ram_dout,
  input  logic [N_IN*DATA_W-1:0]  in_ports,
  output logic [DATA_W-1:0]       read_data,
  output logic                    ram_write,
  output logic [N_OUT*DATA_W-1:0] out_ports,
  output logic                    irq
);

  localparam int unsigned OFF_W      = 7;
  localparam logic [1:0]  CMD_READ   = 2'b01;
  localparam logic [1:0]  CMD_WRITE  = 2'b10;
  localparam logic [OFF_W-1:0] OFF_IN     = 7'h40;
  localparam logic [OFF_W-1:0] OFF_EDGE   = 7'h60;
  localparam logic [OFF_W-1:0] OFF_TLOAD  = 7'h70;
  localparam logic [OFF_W-1:0] OFF_TCTRL  = 7'h71;
  localparam logic [OFF_W-1:0] OFF_TCOUNT = 7'h72;

  // Address decode
  logic             w_rd;
  logic             w_wr;
  logic             w_is_io;
  logic             w_in_window;
  logic             w_wr_io;
  logic [OFF_W-1:0] w_off;

  assign w_rd        = (mem_cmd == CMD_READ);
  assign w_wr        = (mem_cmd == CMD_WRITE);
  assign w_is_io     = mem_addr[ADDR_W-1];
  assign w_in_window = w_is_io && (mem_addr[ADDR_W-1:OFF_W] == IO_BASE[ADDR_W-1:OFF_W]);
  assign w_off       = mem_addr[OFF_W-1:0];
  assign w_wr_io     = w_wr && w_in_window;
  assign ram_write   = w_wr && !w_is_io;

  logic w_edge_wr;
  logic w_tload_wr;
  logic w_tctrl_wr;

  assign w_edge_wr  = w_wr_io && (w_off == OFF_EDGE);
  assign w_tload_wr = w_wr_io && (w_off == OFF_TLOAD);
  assign w_tctrl_wr = w_wr_io && (w_off == OFF_TCTRL);

  // Output port registers
  logic [DATA_W-1:0] r_out [N_OUT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) r_out[i] <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (w_wr_io && (w_off == OFF_W'(i))) r_out[i] <= write_data;
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_ports[g*DATA_W +: DATA_W] = r_out[g];
  end

  // Input synchronizers; IN[0] carries an extra stage for edge detection
  logic [DATA_W-1:0] w_in    [N_IN];
  logic [DATA_W-1:0] r_sync1 [N_IN];
  logic [DATA_W-1:0] r_sync2 [N_IN];
  logic [DATA_W-1:0] r_in0_d;
  logic [DATA_W-1:0] r_edge;
  logic [DATA_W-1:0] w_rise;
  logic [DATA_W-1:0] w_edge_clr;

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    assign w_in[g] = in_ports[g*DATA_W +: DATA_W];
  end

  assign w_rise     = r_sync2[0] & ~r_in0_d;
  assign w_edge_clr = w_edge_wr ? write_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) begin
        r_sync1[i] <= '0;
        r_sync2[i] <= '0;
      end
      r_in0_d <= '0;
      r_edge  <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        r_sync1[i] <= w_in[i];
        r_sync2[i] <= r_sync1[i];
      end
      r_in0_d <= r_sync2[0];
      // A new edge beats a coincident write-1-to-clear on the same bit
      r_edge  <= (r_edge & ~w_edge_clr) | w_rise;
    end
  end

  // Timer
  logic [DATA_W-1:0] r_tload;
  logic [DATA_W-1:0] r_tcount;
  logic              r_en;
  logic              r_auto;
  logic              r_exp;
  logic [DATA_W-1:0] w_tload_nxt;
  logic [DATA_W-1:0] w_tcount_nxt;
  logic              w_en_nxt;
  logic              w_auto_nxt;
  logic              w_exp_nxt;
  logic              w_expire;

  assign w_expire = r_en && (r_tcount == '0);

  always_comb begin
    w_tload_nxt  = r_tload;
    w_tcount_nxt = r_tcount;
    w_en_nxt     = r_en;
    w_auto_nxt   = r_auto;
    w_exp_nxt    = r_exp;
    if (w_expire) begin
      if (r_auto) w_tcount_nxt = r_tload;
      else        w_en_nxt     = 1'b0;
    end else if (r_en) begin
      w_tcount_nxt = r_tcount - DATA_W'(1);
    end
    if (w_tctrl_wr) begin
      w_en_nxt   = write_data[0];
      w_auto_nxt = write_data[1];
      if (write_data[2]) w_exp_nxt = 1'b0;
    end
    if (w_expire) w_exp_nxt = 1'b1;
    // A TLOAD write overrides any decrement or reload in the same cycle
    if (w_tload_wr) begin
      w_tload_nxt  = write_data;
      w_tcount_nxt = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tload  <= '0;
      r_tcount <= '0;
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_exp    <= 1'b0;
    end else begin
      r_tload  <= w_tload_nxt;
      r_tcount <= w_tcount_nxt;
      r_en     <= w_en_nxt;
      r_auto   <= w_auto_nxt;
      r_exp    <= w_exp_nxt;
    end
  end

  assign irq = r_exp;

  // Read mux: zero for anything that is not a READ to RAM or a mapped register
  always_comb begin
    read_data = '0;
    if (w_rd) begin
      if (!w_is_io) begin
        read_data = ram_dout;
      end else if (w_in_window) begin
        for (int i = 0; i < N_OUT; i++) begin
          if (w_off == OFF_W'(i)) read_data = r_out[i];
        end
        for (int i = 0; i < N_IN; i++) begin
          if (w_off == (OFF_IN + OFF_W'(i))) read_data = r_sync2[i];
        end
        case (w_off)
          OFF_EDGE:   read_data = r_edge;
          OFF_TLOAD:  read_data = r_tload;
          OFF_TCTRL:  read_data = DATA_W'({r_exp, r_auto, r_en});
          OFF_TCOUNT: read_data = r_tcount;
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Bench for mmio_ctrl: a register-level model checked every cycle, plus directed scenarios
// with hand-computed literal expectations.
module tb_mmio_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] ram_dout;
  logic [31:0] in_ports;
  logic [15:0] read_data;
  logic        ram_write;
  logic [31:0] out_ports;
  logic        irq;

  mmio_ctrl dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .ram_dout(ram_dout), .in_ports(in_ports),
    .read_data(read_data), .ram_write(ram_write), .out_ports(out_ports), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  logic [31:0] in_drv;
  logic        rst_drv;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Model state: what each register must hold according to the register map rules
  logic [15:0] m_out [2];
  logic [15:0] m_s1 [2];
  logic [15:0] m_s2 [2];
  logic [15:0] m_s3;
  logic [15:0] m_edge;
  logic [15:0] m_tload;
  logic [15:0] m_tcount;
  bit          m_en, m_auto, m_exp;

  // Offset into the I/O window, -1 for RAM
  function automatic int off_of(input logic [8:0] a);
    if (a < 9'h100) return -1;
    return int'(a) - 256;
  endfunction

  function automatic logic [15:0] exp_rdata();
    int o;
    o = off_of(mem_addr);
    if (mem_cmd != 2'b01) return 16'h0;
    if (o == -1) return ram_dout;
    if (o >= 0 && o < 2) return m_out[o];
    if (o >= 'h40 && o < 'h42) return m_s2[o - 'h40];
    if (o == 'h60) return m_edge;
    if (o == 'h70) return m_tload;
    if (o == 'h71) return {13'd0, m_exp, m_auto, m_en};
    if (o == 'h72) return m_tcount;
    return 16'h0;
  endfunction

  task automatic model_step();
    int          o;
    bit          wr, expire;
    logic [15:0] rise, cnt, ld;
    bit          en, au, ex;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin m_out[i] = 0; m_s1[i] = 0; m_s2[i] = 0; end
      m_s3 = 0; m_edge = 0; m_tload = 0; m_tcount = 0;
      m_en = 0; m_auto = 0; m_exp = 0;
      return;
    end
    o  = off_of(mem_addr);
    wr = (mem_cmd == 2'b10);
    rise = m_s2[0] & ~m_s3;
    if (wr && o == 'h60) m_edge = m_edge & ~write_data;
    m_edge = m_edge | rise;
    m_s3 = m_s2[0];
    for (int i = 0; i < 2; i++) begin
      m_s2[i] = m_s1[i];
      m_s1[i] = in_ports[i*16 +: 16];
    end
    if (wr && o >= 0 && o < 2) m_out[o] = write_data;
    cnt = m_tcount; ld = m_tload; en = m_en; au = m_auto; ex = m_exp;
    expire = m_en && (m_tcount == 0);
    if (m_en && m_tcount != 0) cnt = m_tcount - 16'd1;
    if (expire) begin
      if (m_auto) cnt = m_tload;
      else en = 0;
    end
    if (wr && o == 'h71) begin
      en = write_data[0];
      au = write_data[1];
      if (write_data[2]) ex = 0;
    end
    if (expire) ex = 1;
    if (wr && o == 'h70) begin ld = write_data; cnt = write_data; end
    m_tcount = cnt; m_tload = ld; m_en = en; m_auto = au; m_exp = ex;
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("read_data", 32'(read_data), 32'(exp_rdata()));
      check("ram_write", 32'(ram_write), 32'((mem_cmd == 2'b10) && (mem_addr < 9'h100)));
      check("out_ports", out_ports, {m_out[1], m_out[0]});
      check("irq", 32'(irq), 32'(m_exp));
    end
  end

  // Present one command for one cycle; returns mid-cycle, before the committing edge
  task automatic do_cyc(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    reset = rst_drv; mem_cmd = c; mem_addr = a; write_data = d; in_ports = in_drv;
    @(negedge clk); #1;
  endtask

  localparam logic [1:0] NONE = 2'b00, RD = 2'b01, WR = 2'b10;

  logic [8:0] rst_addrs [6];

  initial begin
    reset = 1; rst_drv = 1; mem_cmd = 0; mem_addr = 0; write_data = 0;
    ram_dout = 0; in_drv = 0; in_ports = 0;
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk); #1 reset = 0; rst_drv = 0;
    @(negedge clk); #1;
    check("rst_out_ports", out_ports, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Output register write/readback, unmapped read
    do_cyc(WR, 9'h101, 16'h00A5);
    do_cyc(RD, 9'h101, 16'h0);
    check("out1_port", 32'(out_ports[31:16]), 32'h00A5);
    check("out1_read", 32'(read_data), 32'h00A5);
    do_cyc(RD, 9'h1FF, 16'h0);
    check("unmapped_read", 32'(read_data), 32'h0);

    // Input synchronizer latency and edge capture
    in_drv = {16'h7777, 16'h0003};
    do_cyc(RD, 9'h140, 16'h0); check("in0_lat0", 32'(read_data), 32'h0);
    do_cyc(RD, 9'h140, 16'h0); check("in0_lat1", 32'(read_data), 32'h0);
    do_cyc(RD, 9'h140, 16'h0); check("in0_lat2", 32'(read_data), 32'h3);
    do_cyc(RD, 9'h160, 16'h0); check("edge_set", 32'(read_data), 32'h3);
    do_cyc(RD, 9'h141, 16'h0); check("in1_read", 32'(read_data), 32'h7777);
    do_cyc(WR, 9'h160, 16'h0001);
    do_cyc(RD, 9'h160, 16'h0); check("edge_w1c", 32'(read_data), 32'h2);

    // Edge set coinciding with write-1-to-clear
    in_drv = 32'h0;
    do_cyc(WR, 9'h160, 16'hFFFF);
    do_cyc(NONE, 9'h0, 16'h0);
    do_cyc(NONE, 9'h0, 16'h0);
    in_drv = 32'h1;
    do_cyc(RD, 9'h160, 16'h0); check("edge_clr_all", 32'(read_data), 32'h0);
    do_cyc(NONE, 9'h0, 16'h0);
    do_cyc(WR, 9'h160, 16'h0001);
    do_cyc(RD, 9'h160, 16'h0); check("edge_set_wins", 32'(read_data), 32'h1);
    in_drv = 32'h0;
    do_cyc(WR, 9'h160, 16'hFFFF);
    for (int i = 0; i < 3; i++) do_cyc(NONE, 9'h0, 16'h0);

    // One-shot timer
    do_cyc(WR, 9'h170, 16'd3);
    do_cyc(WR, 9'h171, 16'h1);
    for (int v = 3; v >= 0; v--) begin
      do_cyc(RD, 9'h172, 16'h0);
      check("tcount_oneshot", 32'(read_data), 32'(v));
    end
    do_cyc(RD, 9'h171, 16'h0);
    check("tctrl_expired", 32'(read_data), 32'h4);
    check("irq_expired", 32'(irq), 32'h1);
    do_cyc(WR, 9'h171, 16'h4);
    do_cyc(RD, 9'h171, 16'h0);
    check("tctrl_cleared", 32'(read_data), 32'h0);
    check("irq_cleared", 32'(irq), 32'h0);

    // Auto-reload timer, period 3, with clear on an expiry cycle
    do_cyc(WR, 9'h170, 16'd2);
    do_cyc(WR, 9'h171, 16'h3);
    do_cyc(RD, 9'h172, 16'h0); check("auto_c2", 32'(read_data), 32'd2);
    do_cyc(RD, 9'h172, 16'h0); check("auto_c1", 32'(read_data), 32'd1);
    do_cyc(RD, 9'h172, 16'h0); check("auto_c0", 32'(read_data), 32'd0);
    do_cyc(WR, 9'h171, 16'h7); check("auto_irq1", 32'(irq), 32'h1);
    do_cyc(RD, 9'h171, 16'h0); check("auto_w1c", 32'(read_data), 32'h3);
    check("auto_irq_low", 32'(irq), 32'h0);
    do_cyc(WR, 9'h171, 16'h7);
    do_cyc(RD, 9'h172, 16'h0); check("auto_reload", 32'(read_data), 32'd2);
    check("auto_set_wins", 32'(irq), 32'h1);
    do_cyc(WR, 9'h171, 16'h4);
    do_cyc(NONE, 9'h0, 16'h0);

    // RAM access does not touch I/O
    do_cyc(WR, 9'h010, 16'h1234);
    check("ram_write_hi", 32'(ram_write), 32'h1);
    ram_dout = 16'hBEEF;
    do_cyc(RD, 9'h010, 16'h0);
    check("ram_read", 32'(read_data), 32'hBEEF);
    check("ram_write_lo", 32'(ram_write), 32'h0);
    check("ram_no_io", out_ports, 32'h00A5_0000);

    // Writes to read-only or unmapped offsets are ignored
    do_cyc(WR, 9'h172, 16'h0055);
    do_cyc(WR, 9'h141, 16'h0055);
    do_cyc(WR, 9'h1FF, 16'h0055);
    do_cyc(RD, 9'h172, 16'h0); check("ro_ignored", 32'(read_data), 32'h0);

    // Reset while timer runs and OUT[0] is all ones
    do_cyc(WR, 9'h100, 16'hFFFF);
    do_cyc(WR, 9'h170, 16'd1);
    do_cyc(WR, 9'h171, 16'h3);
    for (int i = 0; i < 3; i++) do_cyc(RD, 9'h171, 16'h0);
    check("pre_rst_irq", 32'(irq), 32'h1);
    check("pre_rst_out0", 32'(out_ports[15:0]), 32'hFFFF);
    rst_drv = 1;
    do_cyc(WR, 9'h100, 16'h5555);
    rst_drv = 0;
    rst_addrs = '{9'h100, 9'h101, 9'h170, 9'h171, 9'h172, 9'h160};
    for (int i = 0; i < 6; i++) begin
      do_cyc(RD, rst_addrs[i], 16'h0);
      check("post_rst_read", 32'(read_data), 32'h0);
      if (i == 0) begin
        check("post_rst_out", out_ports, 32'h0);
        check("post_rst_irq", 32'(irq), 32'h0);
      end
    end
    do_cyc(NONE, 9'h0, 16'h0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
